// File: rtl/sync_edge_detector_pkg.sv
// sync_edge_detector_pkg
//   Shared constants for the synchronizer / edge-detector slice.
//   LOW/HIGH name the logic levels of the active-low reset.
//   YES/NO name boolean flags.
//   MIN_STAGES is the shallowest synchronizer chain that still filters
//   metastability.
package sync_edge_detector_pkg;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;
  localparam logic YES  = 1'b1;
  localparam logic NO   = 1'b0;

  localparam int MIN_STAGES = 2;

endpackage : sync_edge_detector_pkg

// File: rtl/sync_edge_detector_clock_synchronizer.sv
// clock_synchronizer
//   Plain multi-flop synchronizer chain, one independent chain per bit.
//   There is deliberately no reset, so reset can never disturb metastability
//   filtering. Power-up content is whatever the device initialises flops to
//   (zero on the intended targets).
// Parameters:
//   WIDTH  - number of independent bits
//   STAGES - chain depth, must be >= MIN_STAGES
// Ports:
//   clk     in  1      sole clock
//   bit_in  in  WIDTH  asynchronous inputs
//   bit_out out WIDTH  last chain stage
module clock_synchronizer
  import sync_edge_detector_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] bit_in,
  output logic [WIDTH-1:0] bit_out
);

  if (STAGES < MIN_STAGES) begin : g_bad_stages
    $error("clock_synchronizer: STAGES must be at least 2");
  end

  // Adjacent placement of the chain keeps the metastability settle path short.
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_chain [STAGES];

  // Shift the chain; nothing but wire between the stages.
  always_ff @(posedge clk) begin
    r_chain[0] <= bit_in;
    for (int i = 1; i < STAGES; i++) begin
      r_chain[i] <= r_chain[i-1];
    end
  end

  assign bit_out = r_chain[STAGES-1];

endmodule : clock_synchronizer

// File: rtl/sync_edge_detector.sv
// sync_edge_detector
//   Synchronizes an asynchronous bus into clk and emits one-cycle pulses on
//   each rising/falling transition of the synchronized level, per bit.
// Parameters:
//   WIDTH  - number of independent bits (default 1)
//   STAGES - synchronizer depth, >= 2 (default 2)
// Ports:
//   clk       in  1      sole clock
//   reset_low in  1      synchronous reset, active low
//   bit_in    in  WIDTH  asynchronous inputs
//   level     out WIDTH  synchronized level
//   pos_edge  out WIDTH  pulse on 0->1 of level
//   neg_edge  out WIDTH  pulse on 1->0 of level
//   any_edge  out WIDTH  pos_edge | neg_edge
module sync_edge_detector
  import sync_edge_detector_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_low,
  input  logic [WIDTH-1:0] bit_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] pos_edge,
  output logic [WIDTH-1:0] neg_edge,
  output logic [WIDTH-1:0] any_edge
);

  if (STAGES < MIN_STAGES) begin : g_bad_stages
    $error("sync_edge_detector: STAGES must be at least 2");
  end

  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] r_prev;
  logic             w_reset_active;

  clock_synchronizer #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) u_sync (
    .clk     (clk),
    .bit_in  (bit_in),
    .bit_out (w_level)
  );

  assign level          = w_level;
  assign w_reset_active = (reset_low == LOW) ? YES : NO;

  // Previous level. Clearing it on reset makes a high input show up as a
  // pos_edge right after release, so downstream logic learns the high level.
  always_ff @(posedge clk) begin
    if (reset_low == HIGH) begin
      r_prev <= w_level;
    end else begin
      r_prev <= {WIDTH{LOW}};
    end
  end

  // Edge decode, gated combinationally so pulses vanish the same cycle
  // reset is asserted.
  always_comb begin
    pos_edge = {WIDTH{1'b0}};
    neg_edge = {WIDTH{1'b0}};
    any_edge = {WIDTH{1'b0}};
    if (w_reset_active == YES) begin
      pos_edge = {WIDTH{1'b0}};
      neg_edge = {WIDTH{1'b0}};
      any_edge = {WIDTH{1'b0}};
    end else begin
      pos_edge = w_level & ~r_prev;
      neg_edge = ~w_level & r_prev;
      any_edge = w_level ^ r_prev;
    end
  end

endmodule : sync_edge_detector

// File: tb/tb_sync_edge_detector.sv
// Scoreboard bench for sync_edge_detector. Two instances: A (WIDTH=1,
// STAGES=2) and B (WIDTH=4, STAGES=3). Each stimulus cycle records the
// inputs and pushes the expected outputs for that cycle; a monitor on the
// falling edge pops and compares.
module tb_sync_edge_detector;

  localparam int MAXC = 1024;

  logic       clk = 1'b0;
  logic       reset_low = 1'b0;
  logic       a_in = 1'b0;
  logic [3:0] b_in = 4'b0000;

  logic       a_level, a_pos, a_neg, a_any;
  logic [3:0] b_level, b_pos, b_neg, b_any;

  always #5 clk = ~clk;

  sync_edge_detector #(.WIDTH(1), .STAGES(2)) dut_a (
    .clk       (clk),
    .reset_low (reset_low),
    .bit_in    (a_in),
    .level     (a_level),
    .pos_edge  (a_pos),
    .neg_edge  (a_neg),
    .any_edge  (a_any)
  );

  sync_edge_detector #(.WIDTH(4), .STAGES(3)) dut_b (
    .clk       (clk),
    .reset_low (reset_low),
    .bit_in    (b_in),
    .level     (b_level),
    .pos_edge  (b_pos),
    .neg_edge  (b_neg),
    .any_edge  (b_any)
  );

  typedef struct packed {
    logic       chk;
    int         cyc;
    logic [3:0] la, pa, na, aa;
    logic [3:0] lb, pb, nb, ab;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] hist_a [MAXC];
  logic [3:0] hist_b [MAXC];
  logic       hist_r [MAXC];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  // Reference: level is the input driven `stages` cycles earlier (0 before
  // time began); the remembered level is last cycle's level unless reset was
  // held last cycle; edges are level changes against it, nothing while reset.
  function automatic logic [3:0] ref_level(input bit is_b, input int j);
    int idx;
    idx = j - (is_b ? 3 : 2);
    if (idx < 0) return 4'b0000;
    return is_b ? hist_b[idx] : hist_a[idx];
  endfunction

  function automatic logic [3:0] ref_prev(input bit is_b, input int j);
    if (j < 1) return 4'b0000;
    if (hist_r[j-1] == 1'b0) return 4'b0000;
    return ref_level(is_b, j - 1);
  endfunction

  task automatic step(input logic rst_n, input logic a, input logic [3:0] b);
    exp_t       e;
    logic [3:0] l, p;
    @(posedge clk);
    #1;
    reset_low = rst_n;
    a_in      = a;
    b_in      = b;
    hist_r[cyc] = rst_n;
    hist_a[cyc] = {3'b000, a};
    hist_b[cyc] = b;
    e.chk = (cyc >= 4);
    e.cyc = cyc;
    l = ref_level(1'b0, cyc);
    p = ref_prev(1'b0, cyc);
    e.la = l;
    e.pa = rst_n ? (l & ~p) : 4'b0000;
    e.na = rst_n ? (~l & p & 4'b0001) : 4'b0000;
    e.aa = e.pa | e.na;
    l = ref_level(1'b1, cyc);
    p = ref_prev(1'b1, cyc);
    e.lb = l;
    e.pb = rst_n ? (l & ~p) : 4'b0000;
    e.nb = rst_n ? (~l & p) : 4'b0000;
    e.ab = e.pb | e.nb;
    sb.push_back(e);
    cyc++;
  endtask

  task automatic cmp(input string name, input int c, input logic [3:0] act,
                     input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", name, c, act, exp);
    end
  endtask

  // Monitor: outputs are present every cycle; compare away from posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          cmp("a_level", e.cyc, {3'b000, a_level}, e.la);
          cmp("a_pos",   e.cyc, {3'b000, a_pos},   e.pa);
          cmp("a_neg",   e.cyc, {3'b000, a_neg},   e.na);
          cmp("a_any",   e.cyc, {3'b000, a_any},   e.aa);
          cmp("b_level", e.cyc, b_level, e.lb);
          cmp("b_pos",   e.cyc, b_pos,   e.pb);
          cmp("b_neg",   e.cyc, b_neg,   e.nb);
          cmp("b_any",   e.cyc, b_any,   e.ab);
        end
      end
    end
  end

  initial begin
    // Reset with inputs low, then idle.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 4'b0000);
    // Latency: rise then fall on A.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'b0000);
    // High input held through reset.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'b0000);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'b0000);
    // Fast toggling.
    for (int i = 0; i < 8; i++) step(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 4'b0000);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'b0000);
    // Reset in the cycle A's pos_edge would fire, then release.
    step(1'b1, 1'b1, 4'b0000);
    step(1'b1, 1'b1, 4'b0000);
    step(1'b0, 1'b1, 4'b0000);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'b0000);
    // Multi-bit on B.
    step(1'b1, 1'b1, 4'b0000);
    step(1'b1, 1'b1, 4'b0101);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'b1100);
    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1,
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'b0000);
    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sync_edge_detector
